// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add multiplier controller for the ALU MUL opcode.
// One partial-product step per clock; BUSY stalls the PC, DONE qualifies the write-back.
module mul_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;

    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;
    logic               w_busy;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = (r_cnt == LastCnt);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (START) begin
                        r_mcand  <= {{WIDTH{1'b0}}, OPERAND1};
                        r_mplier <= OPERAND2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Final step: capture the completed product so it is valid with DONE.
                    if (w_last) begin
                        r_state     <= StFinish;
                        r_done      <= 1'b1;
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // BUSY follows START combinationally in IDLE so the PC stalls in the decode cycle.
    always_comb begin
        w_busy = 1'b0;
        if (!RESET) begin
            unique case (r_state)
                StIdle:   w_busy = START;
                StRun:    w_busy = 1'b1;
                StFinish: w_busy = 1'b0;
                default:  w_busy = 1'b0;
            endcase
        end
    end

    assign BUSY      = w_busy;
    assign DONE      = r_done;
    assign RESULT    = r_result;
    assign RESULT_HI = r_result_hi;

endmodule
